// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset vector, bubble encoding, fetch FSM states.
package mips_pkg;

  localparam logic [31:0] RESET_PC        = 32'h0000_0000;
  localparam logic [31:0] NOP_INST        = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to imem over a ready handshake, and
// drains a stale in-flight request after a redirect.
module fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_inst,
  output logic        IF_Flush,
  output logic        fetch_stall
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_addr_q;
  logic [31:0]  inst_buf_q;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;

  assign w_redirect = Branch_Taken | Jump;
  assign w_target   = word_align(Branch_Taken ? Branch_Target : Jump_Target);
  assign w_pc_inc   = pc_q + 32'd4;

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    IF_inst     = NOP_INST;
    fetch_stall = 1'b1;
    IF_Flush    = w_redirect & ~rst;
    IF_PC       = rst ? (RESET_PC + 32'd4) : w_pc_inc;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            fetch_stall = 1'b0;
            // A redirected response is dropped; IF/ID is flushed anyway.
            if (!w_redirect) IF_inst = imem_rdata;
          end
        end
        S_HOLD: begin
          IF_inst     = inst_buf_q;
          fetch_stall = 1'b0;
        end
        S_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = req_addr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'd0;
      inst_buf_q <= NOP_INST;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            if (w_redirect)    pc_q <= w_target;
            else if (PC_Write) pc_q <= w_pc_inc;
            else begin
              inst_buf_q <= imem_rdata;
              state_q    <= S_HOLD;
            end
          end else if (w_redirect) begin
            // Keep the outstanding address on the bus until imem answers.
            req_addr_q <= pc_q;
            pc_q       <= w_target;
            state_q    <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            pc_q    <= w_target;
            state_q <= S_FETCH;
          end else if (PC_Write) begin
            pc_q    <= w_pc_inc;
            state_q <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (w_redirect) pc_q    <= w_target;
          if (imem_ready) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential, hold, redirect, drain, wrap, reset-in-drain.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_Write;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_inst;
  logic        IF_Flush;
  logic        fetch_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Jump(Jump), .Jump_Target(Jump_Target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_PC(IF_PC), .IF_inst(IF_inst), .IF_Flush(IF_Flush),
    .fetch_stall(fetch_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge to sample.
  task automatic drive(input logic r, input logic pw, input logic bt, input logic [31:0] btgt,
                       input logic j, input logic [31:0] jtgt, input logic rdy,
                       input logic [31:0] rdata);
    @(posedge clk); #1;
    rst = r; PC_Write = pw; Branch_Taken = bt; Branch_Target = btgt;
    Jump = j; Jump_Target = jtgt; imem_ready = rdy; imem_rdata = rdata;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; PC_Write = 1'b1; Branch_Taken = 1'b0; Branch_Target = '0;
    Jump = 1'b0; Jump_Target = '0; imem_ready = 1'b0; imem_rdata = '0;

    // Reset with a jump pending: outputs forced quiet.
    drive(1, 1, 0, 0, 1, 32'h0000_0500, 1, 32'h1234_5678);
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_ifpc",  IF_PC,                32'h4);
    chk("rst_flush", {31'd0, IF_Flush},    32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd1);
    chk("rst_inst",  IF_inst,              32'h0);

    // Sequential fetch, zero-wait.
    drive(0, 1, 0, 0, 0, 0, 1, 32'h1111_0000);
    chk("seq0_addr", imem_addr, 32'h0);
    chk("seq0_req",  {31'd0, imem_req}, 32'd1);
    chk("seq0_ifpc", IF_PC, 32'h4);
    chk("seq0_inst", IF_inst, 32'h1111_0000);
    drive(0, 1, 0, 0, 0, 0, 1, 32'h1111_0004);
    chk("seq1_addr", imem_addr, 32'h4);
    chk("seq1_ifpc", IF_PC, 32'h8);

    // Stall at 0x8: word captured, then held with no request.
    drive(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_0008);
    chk("seq2_addr", imem_addr, 32'h8);
    chk("seq2_ifpc", IF_PC, 32'hC);
    chk("seq2_inst", IF_inst, 32'hDEAD_0008);
    drive(0, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    chk("hold1_req",  {31'd0, imem_req}, 32'd0);
    chk("hold1_inst", IF_inst, 32'hDEAD_0008);
    chk("hold1_stall", {31'd0, fetch_stall}, 32'd0);
    drive(0, 1, 0, 0, 0, 0, 1, 32'hBAD0_BAD1);
    chk("hold2_req",  {31'd0, imem_req}, 32'd0);
    chk("hold2_inst", IF_inst, 32'hDEAD_0008);
    drive(0, 1, 0, 0, 0, 0, 1, 32'h1111_000C);
    chk("post_hold_addr", imem_addr, 32'hC);
    chk("post_hold_inst", IF_inst, 32'h1111_000C);

    // Branch at 0x10 with misaligned target 0x43 -> 0x40.
    drive(0, 1, 1, 32'h0000_0043, 0, 0, 1, 32'h1111_0010);
    chk("br_addr",  imem_addr, 32'h10);
    chk("br_flush", {31'd0, IF_Flush}, 32'd1);
    drive(0, 1, 0, 0, 1, 32'h0000_0020, 1, 32'h1111_0040);
    chk("br_tgt_addr", imem_addr, 32'h40);

    // Redirect to 0x80 while 0x20 is pending.
    drive(0, 1, 0, 0, 1, 32'h0000_0080, 0, 32'h0);
    chk("pend_addr",  imem_addr, 32'h20);
    chk("pend_flush", {31'd0, IF_Flush}, 32'd1);
    chk("pend_stall", {31'd0, fetch_stall}, 32'd1);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("drain1_addr", imem_addr, 32'h20);
    chk("drain1_req",  {31'd0, imem_req}, 32'd1);
    chk("drain1_inst", IF_inst, 32'h0);
    chk("drain1_ifpc", IF_PC, 32'h84);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("drain2_addr", imem_addr, 32'h20);
    drive(0, 1, 0, 0, 0, 0, 1, 32'h5717_E000);
    chk("drain3_addr",  imem_addr, 32'h20);
    chk("drain3_inst",  IF_inst, 32'h0);
    chk("drain3_stall", {31'd0, fetch_stall}, 32'd1);

    // Branch and jump together: branch wins.
    drive(0, 1, 1, 32'h0000_0100, 1, 32'h0000_0200, 1, 32'h1111_0080);
    chk("after_drain_addr", imem_addr, 32'h80);
    drive(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h1111_0100);
    chk("both_addr", imem_addr, 32'h100);

    // PC wrap.
    drive(0, 1, 0, 0, 0, 0, 1, 32'h1111_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_ifpc", IF_PC, 32'h0);
    drive(0, 1, 0, 0, 0, 0, 1, 32'h1111_0000);
    chk("wrap_next", imem_addr, 32'h0);

    // Drain from 0x4: latest redirect during drain wins.
    drive(0, 1, 0, 0, 1, 32'h0000_0300, 0, 32'h0);
    chk("d2_start_addr", imem_addr, 32'h4);
    drive(0, 1, 0, 0, 1, 32'h0000_0400, 0, 32'h0);
    chk("d2_hold_addr", imem_addr, 32'h4);
    drive(0, 1, 0, 0, 0, 0, 1, 32'h0);
    chk("d2_done_addr", imem_addr, 32'h4);
    drive(0, 1, 0, 0, 1, 32'h0000_0500, 0, 32'h0);
    chk("latest_addr", imem_addr, 32'h400);

    // Reset in the middle of a drain of 0x400.
    drive(1, 1, 0, 0, 1, 32'h0000_0600, 0, 32'h0);
    chk("rdrain_req",   {31'd0, imem_req}, 32'd0);
    chk("rdrain_flush", {31'd0, IF_Flush}, 32'd0);
    chk("rdrain_ifpc",  IF_PC, 32'h4);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
    chk("post_rst_ifpc", IF_PC, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
